// File: rtl/car_pkg.sv
// car_pkg: shared mode, state and move-bit definitions for the motion path.
package car_pkg;
  localparam logic [1:0] MODE_OFF  = 2'd0;
  localparam logic [1:0] MODE_MAN  = 2'd1;
  localparam logic [1:0] MODE_AUTO = 2'd2;
  localparam logic [1:0] MODE_SEMI = 2'd3;
  localparam int MV_FWD   = 3;
  localparam int MV_BWD   = 2;
  localparam int MV_LEFT  = 1;
  localparam int MV_RIGHT = 0;
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SWITCH  = 3'd1,
    ST_RUN     = 3'd2,
    ST_DEAD    = 3'd3,
    ST_BARRIER = 3'd4
  } state_t;
  function automatic logic [3:0] sanitize_move(input logic [3:0] m);
    logic [3:0] s;
    s = m;
    if (m[MV_FWD] && m[MV_BWD]) begin
      s[MV_FWD] = 1'b0;
      s[MV_BWD] = 1'b0;
    end
    if (m[MV_LEFT] && m[MV_RIGHT]) begin
      s[MV_LEFT]  = 1'b0;
      s[MV_RIGHT] = 1'b0;
    end
    return s;
  endfunction
  function automatic logic [1:0] sanitize_bar(input logic [1:0] b);
    return (&b) ? 2'b00 : b;
  endfunction
endpackage

// File: rtl/motion_arbiter_if.sv
// motion_arbiter_if: mode-generator requests in, device commands and debug state out.
interface motion_arbiter_if;
  logic [1:0] mode;
  logic [3:0] man_move;
  logic [3:0] semi_move;
  logic [3:0] auto_move;
  logic [1:0] man_barrier;
  logic [1:0] auto_barrier;
  logic [3:0] move_signal;
  logic       place_barrier;
  logic       destroy_barrier;
  logic [2:0] state_out;
  modport master (
    output mode, man_move, semi_move, auto_move, man_barrier, auto_barrier,
    input  move_signal, place_barrier, destroy_barrier, state_out
  );
  modport slave (
    input  mode, man_move, semi_move, auto_move, man_barrier, auto_barrier,
    output move_signal, place_barrier, destroy_barrier, state_out
  );
endinterface

// File: rtl/hold_timer.sv
// hold_timer: loadable saturating down-counter; done flags the last cycle of a hold (count of 1).
module hold_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  assign done = (cnt == CNT_W'(1));
endmodule

// File: rtl/motion_arbiter.sv
// motion_arbiter: selects the active mode's motion request, inserts stop intervals on
// mode switches and reversals, and issues barrier commands as fixed pulses while stopped.
module motion_arbiter
  import car_pkg::*;
#(
  parameter int DEAD_TIME     = 4,
  parameter int BARRIER_PULSE = 3,
  parameter int CNT_W         = 3
) (
  input logic           clk,
  input logic           reset,
  motion_arbiter_if.slave bus
);
  state_t           state, state_d;
  logic [1:0]       mode_q, bar_q, sel_bar, san_bar, ev;
  logic [3:0]       sel_move, san_move, move_q, move_d;
  logic             place_q, destroy_q, place_d, destroy_d;
  logic             load, en, done, rev;
  logic [CNT_W-1:0] load_val;
  always_comb begin
    sel_move = (mode_q == MODE_MAN)  ? bus.man_move  :
               (mode_q == MODE_AUTO) ? bus.auto_move :
               (mode_q == MODE_SEMI) ? bus.semi_move : 4'b0000;
    sel_bar  = (mode_q == MODE_MAN)  ? bus.man_barrier  :
               (mode_q == MODE_AUTO) ? bus.auto_barrier : 2'b00;
  end
  assign san_move = sanitize_move(sel_move);
  assign san_bar  = sanitize_bar(sel_bar);
  // bar_q follows the request every cycle, so a level held through a stop never fires later
  assign ev       = san_bar & ~bar_q;
  assign rev      = (move_q[MV_FWD] & san_move[MV_BWD]) | (move_q[MV_BWD] & san_move[MV_FWD]);
  assign en       = (state == ST_SWITCH) || (state == ST_DEAD) || (state == ST_BARRIER);
  hold_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .rst_n   (reset),
    .load    (load),
    .en      (en),
    .load_val(load_val),
    .done    (done)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= ST_IDLE;
    else state <= state_d;
  always_comb begin
    state_d  = state;
    load     = 1'b0;
    load_val = CNT_W'(DEAD_TIME);
    if (bus.mode == MODE_OFF) state_d = ST_IDLE;
    else if (state == ST_IDLE || bus.mode != mode_q) begin
      state_d = ST_SWITCH;
      load    = 1'b1;
    end else
      case (state)
        ST_SWITCH: state_d = done ? ST_RUN : ST_SWITCH;
        ST_RUN:
          if (ev != 2'b00) begin
            state_d  = ST_BARRIER;
            load     = 1'b1;
            load_val = CNT_W'(BARRIER_PULSE);
          end else if (rev) begin
            state_d = ST_DEAD;
            load    = 1'b1;
          end
        ST_DEAD, ST_BARRIER: state_d = done ? ST_RUN : state;
        default: state_d = ST_IDLE;
      endcase
  end
  // SWITCH hands over with one idle RUN cycle; DEAD/BARRIER exits drive the live request at once
  always_comb begin
    move_d    = (state_d == ST_RUN && state != ST_SWITCH) ? san_move : 4'b0000;
    place_d   = (state_d == ST_BARRIER) && ((state == ST_BARRIER) ? place_q : ev[1]);
    destroy_d = (state_d == ST_BARRIER) && ((state == ST_BARRIER) ? destroy_q : ev[0]);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mode_q    <= MODE_OFF;
      bar_q     <= 2'b00;
      move_q    <= 4'b0000;
      place_q   <= 1'b0;
      destroy_q <= 1'b0;
    end else begin
      mode_q    <= bus.mode;
      bar_q     <= san_bar;
      move_q    <= move_d;
      place_q   <= place_d;
      destroy_q <= destroy_d;
    end
  assign bus.move_signal     = move_q;
  assign bus.place_barrier   = place_q;
  assign bus.destroy_barrier = destroy_q;
  assign bus.state_out       = state;
endmodule

// File: tb/tb_motion_arbiter.sv
// tb_motion_arbiter: directed scenarios plus randomized traffic against a cycle reference model.
module tb_motion_arbiter;
  localparam int DT = 4;
  localparam int BP = 3;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  motion_arbiter_if bus();
  motion_arbiter #(.DEAD_TIME(DT), .BARRIER_PULSE(BP), .CNT_W(3)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  // reference model: phase 0 idle, 1 switch, 2 run, 3 dead, 4 barrier; left = cycles still to hold
  int         ph, left;
  logic [1:0] m_mode, m_pbar;
  logic [3:0] m_move;
  logic       m_place, m_destroy;
  function automatic logic [3:0] clean_move(input logic [3:0] r);
    logic [3:0] c;
    c = r;
    if (r[3] && r[2]) c[3:2] = 2'b00;
    if (r[1] && r[0]) c[1:0] = 2'b00;
    return c;
  endfunction
  function automatic logic [1:0] clean_bar(input logic [1:0] b);
    return (b == 2'b11) ? 2'b00 : b;
  endfunction
  task automatic model_clear();
    ph = 0; left = 0; m_mode = 2'd0; m_pbar = 2'b00;
    m_move = 4'b0000; m_place = 1'b0; m_destroy = 1'b0;
  endtask
  task automatic model_step();
    logic [3:0] req;
    logic [1:0] bar, ev;
    if (!reset) begin
      model_clear();
      return;
    end
    case (m_mode)
      2'd1: begin req = bus.man_move;  bar = bus.man_barrier;  end
      2'd2: begin req = bus.auto_move; bar = bus.auto_barrier; end
      2'd3: begin req = bus.semi_move; bar = 2'b00;            end
      default: begin req = 4'b0000;    bar = 2'b00;            end
    endcase
    req = clean_move(req);
    bar = clean_bar(bar);
    ev  = bar & ~m_pbar;
    if (bus.mode == 2'd0) begin
      ph = 0; m_move = 4'b0000; m_place = 1'b0; m_destroy = 1'b0;
    end else if (ph == 0 || bus.mode != m_mode) begin
      ph = 1; left = DT; m_move = 4'b0000; m_place = 1'b0; m_destroy = 1'b0;
    end else if (ph == 1) begin
      left--;
      if (left == 0) ph = 2;
    end else if (ph == 2) begin
      if (ev != 2'b00) begin
        ph = 4; left = BP; m_move = 4'b0000; m_place = ev[1]; m_destroy = ev[0];
      end else if ((m_move[3] && req[2]) || (m_move[2] && req[3])) begin
        ph = 3; left = DT; m_move = 4'b0000;
      end else m_move = req;
    end else begin
      left--;
      if (left == 0) begin
        ph = 2; m_move = req; m_place = 1'b0; m_destroy = 1'b0;
      end
    end
    m_mode = bus.mode;
    m_pbar = bar;
  endtask
  function automatic logic [8:0] got();
    return {bus.move_signal, bus.place_barrier, bus.destroy_barrier, bus.state_out};
  endfunction
  function automatic logic [8:0] expv();
    return {m_move, m_place, m_destroy, 3'(ph)};
  endfunction
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic test_reset();
    tick();
    tick();
    checks++;
    if (got() !== 9'b0) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", got(), 9'b0);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (got() !== expv()) begin
      failures++;
      $display("FAIL reset_release got=%b exp=%b", got(), expv());
    end
  endtask
  task automatic test_switch();
    bus.mode = 2'd1;
    bus.man_move = 4'b1000;
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++;
      if (got() !== expv()) begin
        failures++;
        $display("FAIL switch_model cyc=%0d got=%b exp=%b", i, got(), expv());
      end
      checks++;
      if (bus.state_out !== ((i <= 4) ? 3'd1 : 3'd2) || bus.move_signal !== ((i == 6) ? 4'b1000 : 4'b0000)) begin
        failures++;
        $display("FAIL switch_seq cyc=%0d state=%0d move=%b", i, bus.state_out, bus.move_signal);
      end
    end
  endtask
  task automatic test_reversal();
    int zeros;
    bit seen;
    zeros = 0;
    seen = 0;
    bus.man_move = 4'b0100;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      checks++;
      if (got() !== expv()) begin
        failures++;
        $display("FAIL reversal_model cyc=%0d got=%b exp=%b", i, got(), expv());
      end
      checks++;
      if (bus.move_signal == 4'b1100 || (i == 0 && bus.state_out !== 3'd3)) begin
        failures++;
        $display("FAIL reversal_state cyc=%0d state=%0d move=%b", i, bus.state_out, bus.move_signal);
      end
      if (bus.move_signal == 4'b0000) zeros++;
      if (bus.move_signal == 4'b0100) seen = 1;
    end
    checks++;
    if (!seen || zeros != DT) begin
      failures++;
      $display("FAIL reversal_gap zeros=%0d exp=%0d reached=%0d", zeros, DT, seen);
    end
  endtask
  task automatic test_barrier();
    int highs, rises;
    logic prev;
    bus.man_move = 4'b0010;
    tick();
    tick();
    highs = 0; rises = 0; prev = 1'b0;
    bus.man_barrier = 2'b10;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (got() !== expv() || (bus.place_barrier && bus.move_signal !== 4'b0000)) begin
        failures++;
        $display("FAIL barrier_model cyc=%0d got=%b exp=%b", i, got(), expv());
      end
      if (bus.place_barrier) highs++;
      if (bus.place_barrier && !prev) rises++;
      prev = bus.place_barrier;
    end
    checks++;
    if (highs != BP || rises != 1) begin
      failures++;
      $display("FAIL barrier_pulse highs=%0d rises=%0d exp=%0d/1", highs, rises, BP);
    end
    highs = 0;
    bus.man_barrier = 2'b11;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) bus.man_barrier = 2'b00;
      if (i == 5) bus.man_barrier = 2'b11;
      tick();
      checks++;
      if (got() !== expv()) begin
        failures++;
        $display("FAIL barrier_both_model cyc=%0d got=%b exp=%b", i, got(), expv());
      end
      if (bus.place_barrier || bus.destroy_barrier) highs++;
    end
    checks++;
    if (highs != 0) begin
      failures++;
      $display("FAIL barrier_both pulses=%0d exp=0", highs);
    end
    bus.man_barrier = 2'b00;
  endtask
  task automatic test_mode_abort();
    bus.mode = 2'd2;
    bus.auto_move = 4'b0001;
    bus.auto_barrier = 2'b00;
    for (int i = 0; i < 6; i++) tick();
    bus.auto_barrier = 2'b01;
    tick();
    checks++;
    if (bus.destroy_barrier !== 1'b1 || bus.state_out !== 3'd4 || got() !== expv()) begin
      failures++;
      $display("FAIL abort_pulse_start got=%b exp=%b", got(), expv());
    end
    tick();
    bus.mode = 2'd3;
    bus.semi_move = 4'b1000;
    bus.auto_barrier = 2'b10;
    for (int i = 1; i <= 8; i++) begin
      if (i == 7) bus.auto_barrier = 2'b00;
      tick();
      checks++;
      if (got() !== expv()) begin
        failures++;
        $display("FAIL abort_model cyc=%0d got=%b exp=%b", i, got(), expv());
      end
      checks++;
      if ((i <= 6 && bus.state_out !== ((i <= 4) ? 3'd1 : 3'd2)) || (i <= 6 && bus.move_signal !== ((i == 6) ? 4'b1000 : 4'b0000))
          || bus.place_barrier || bus.destroy_barrier) begin
        failures++;
        $display("FAIL abort_seq cyc=%0d state=%0d move=%b pd=%b%b", i, bus.state_out, bus.move_signal, bus.place_barrier, bus.destroy_barrier);
      end
    end
  endtask
  task automatic test_sanitise_idle();
    bus.semi_move = 4'b1111;
    tick();
    checks++;
    if (bus.move_signal !== 4'b0000 || bus.state_out !== 3'd2 || got() !== expv()) begin
      failures++;
      $display("FAIL sanitise_all got=%b exp=%b", got(), expv());
    end
    bus.semi_move = 4'b1101;
    tick();
    checks++;
    if (bus.move_signal !== 4'b0001 || got() !== expv()) begin
      failures++;
      $display("FAIL sanitise_fb got=%b exp=%b", got(), expv());
    end
    bus.semi_move = 4'b1000;
    tick();
    bus.semi_move = 4'b0100;
    tick();
    checks++;
    if (bus.state_out !== 3'd3 || got() !== expv()) begin
      failures++;
      $display("FAIL dead_entry got=%b exp=%b", got(), expv());
    end
    tick();
    bus.mode = 2'd0;
    tick();
    checks++;
    if (got() !== 9'b0 || got() !== expv()) begin
      failures++;
      $display("FAIL dead_abort got=%b exp=%b", got(), 9'b0);
    end
  endtask
  task automatic test_async_reset();
    bit seen;
    seen = 0;
    bus.mode = 2'd1;
    bus.man_move = 4'b1000;
    bus.man_barrier = 2'b00;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      checks++;
      if (got() !== expv()) begin
        failures++;
        $display("FAIL areset_model cyc=%0d got=%b exp=%b", i, got(), expv());
      end
      if (bus.move_signal == 4'b1000) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL areset_run_timeout move=%b exp=1000", bus.move_signal);
    end
    #2 reset = 1'b0;
    #1;
    model_clear();
    checks++;
    if (got() !== 9'b0) begin
      failures++;
      $display("FAIL areset_immediate got=%b exp=%b", got(), 9'b0);
    end
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (got() !== expv()) begin
      failures++;
      $display("FAIL areset_release got=%b exp=%b", got(), expv());
    end
  endtask
  task automatic test_random();
    logic [3:0] ms;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 39) == 0) bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) bus.man_move = 4'($urandom);
      if ($urandom_range(0, 3) == 0) bus.semi_move = 4'($urandom);
      if ($urandom_range(0, 3) == 0) bus.auto_move = 4'($urandom);
      if ($urandom_range(0, 7) == 0) bus.man_barrier = 2'($urandom);
      if ($urandom_range(0, 7) == 0) bus.auto_barrier = 2'($urandom);
      tick();
      checks++;
      if (got() !== expv()) begin
        failures++;
        $display("FAIL random_model cyc=%0d got=%b exp=%b", i, got(), expv());
      end
      ms = bus.move_signal;
      checks++;
      if ((ms[3] & ms[2]) || (ms[1] & ms[0]) || (bus.place_barrier & bus.destroy_barrier)
          || ((bus.place_barrier | bus.destroy_barrier) && ms != 4'b0000)) begin
        failures++;
        $display("FAIL random_invariant cyc=%0d move=%b place=%b destroy=%b", i, ms, bus.place_barrier, bus.destroy_barrier);
      end
    end
  endtask
  initial begin
    bus.mode = 2'd0;
    bus.man_move = 4'b0000;
    bus.semi_move = 4'b0000;
    bus.auto_move = 4'b0000;
    bus.man_barrier = 2'b00;
    bus.auto_barrier = 2'b00;
    model_clear();
    test_reset();
    test_switch();
    test_reversal();
    test_barrier();
    test_mode_abort();
    test_sanitise_idle();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1);
  end
endmodule
